my_serial_port: RTL and testbench

UART serial port peripheral that sits on the far end of the data memory's serial link. It accepts bytes from the memory-side write strobe and transmits them as 8N1 frames on `uart_txd_out`. It receives 8N1 frames on `uart_rxd_in` and presents them to the memory side through a show-ahead FIFO with valid/read-enable handshaking. Memory-side ports connect one-to-one to the data memory's `serial_*` ports (its `serial_out` drives our `serial_data_in`, our `serial_data_out` drives its `serial_in`, and so on).

---
 rtl/my_serial_port_if.sv | 29 ++
 rtl/my_serial_port.sv | 258 +++++++++++++++++++++++++
 tb/tb_my_serial_port.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/my_serial_port_if.sv
// Memory-side serial link between the data memory and the UART peripheral.
interface my_serial_port_if;
  logic [7:0] serial_data_in;
  logic       serial_wren_in;
  logic       serial_rden_in;
  logic [7:0] serial_data_out;
  logic       serial_ready_out;
  logic       serial_valid_out;

  // Data memory side: pushes TX bytes, pops RX bytes.
  modport master (
    output serial_data_in,
    output serial_wren_in,
    output serial_rden_in,
    input  serial_data_out,
    input  serial_ready_out,
    input  serial_valid_out
  );

  // UART peripheral side.
  modport slave (
    input  serial_data_in,
    input  serial_wren_in,
    input  serial_rden_in,
    output serial_data_out,
    output serial_ready_out,
    output serial_valid_out
  );
endinterface

// File: rtl/my_serial_port.sv
// UART peripheral: 8N1 transmitter and receiver, each buffered by a small FIFO.
//
// TX FSM
//   state       | meaning
//   TX_IDLE     | line high; pops the FIFO head when one is waiting
//   TX_START    | start bit (0) for CLKS_PER_BIT cycles
//   TX_DATA     | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   TX_STOP     | stop bit (1) for CLKS_PER_BIT cycles
//
// RX FSM
//   state        | meaning
//   RX_IDLE      | waiting for a synchronized 1->0 transition
//   RX_START     | half a bit, then confirm the start bit is still 0
//   RX_DATA      | sample 8 bits at mid-bit, LSB first
//   RX_STOP      | sample the stop bit; push on 1, framing error on 0
//   RX_WAIT_HIGH | after a framing error, wait for the line to go high
//
// CLKS_PER_BIT must be even and >= 4; FIFO_DEPTH a power of 2, >= 2.
module my_serial_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  my_serial_port_if.slave  bus,
  input  logic             uart_rxd_in,
  output logic             uart_txd_out,
  output logic             rx_overrun_out,
  output logic             rx_frame_err_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] tx_count;
  logic          tx_full, tx_push, tx_pop;

  assign tx_full              = (tx_count == FULL_CNT);
  assign bus.serial_ready_out = ~tx_full;
  assign tx_push              = bus.serial_wren_in & ~tx_full;

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
    end
  end

  // TX FIFO storage; stale entries are harmless once the pointers reset.
  always_ff @(posedge clock) begin
    if (reset && tx_push) tx_mem[tx_wr_ptr] <= bus.serial_data_in;
  end

  // ---------------- TX FSM ----------------
  tx_state_t     tx_state, tx_next;
  logic [BW-1:0] tx_baud;
  logic [2:0]    tx_bit_cnt;
  logic [7:0]    tx_shift;
  logic          tx_line;

  // TX state register.
  always_ff @(posedge clock) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // TX next-state logic.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_count != '0) tx_next = TX_START;
      TX_START: if (tx_baud == '0) tx_next = TX_DATA;
      TX_DATA:  if (tx_baud == '0 && tx_bit_cnt == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_baud == '0) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: FIFO pop request and the line level for the next register.
  always_comb begin
    tx_pop  = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      TX_IDLE:  tx_pop  = (tx_count != '0);
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift[0];
      default:  tx_line = 1'b1;
    endcase
  end

  // TX baud down-counter, bit counter, shift register and registered line.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_baud      <= '0;
      tx_bit_cnt   <= '0;
      tx_shift     <= '0;
      uart_txd_out <= 1'b1;
    end else begin
      uart_txd_out <= tx_line;
      if (tx_pop) begin
        tx_shift   <= tx_mem[tx_rd_ptr];
        tx_baud    <= BAUD_LAST;
        tx_bit_cnt <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_baud == '0) begin
          tx_baud <= BAUD_LAST;
          if (tx_state == TX_DATA) begin
            tx_shift   <= {1'b0, tx_shift[7:1]};
            tx_bit_cnt <= tx_bit_cnt + 3'd1;
          end
        end else begin
          tx_baud <= tx_baud - BW'(1);
        end
      end
    end
  end

  // ---------------- RX synchronizer ----------------
  logic rx_s1, rx_s2, rx_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rxd_in;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t     rx_state, rx_next;
  logic [BW-1:0] rx_baud;
  logic [2:0]    rx_bit_cnt;
  logic [7:0]    rx_shift;
  logic          rx_push_req, rx_ferr_set;

  // RX state register.
  always_ff @(posedge clock) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // RX next-state logic.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (rx_d && !rx_s2) rx_next = RX_START;
      RX_START:     if (rx_baud == '0) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_baud == '0 && rx_bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (rx_baud == '0) rx_next = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  // RX outputs: stop-bit verdict.
  always_comb begin
    rx_push_req = 1'b0;
    rx_ferr_set = 1'b0;
    if (rx_state == RX_STOP && rx_baud == '0) begin
      rx_push_req = rx_s2;
      rx_ferr_set = ~rx_s2;
    end
  end

  // RX baud down-counter (half bit first), bit counter and shift register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_baud    <= '0;
      rx_bit_cnt <= '0;
      rx_shift   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_baud    <= BAUD_HALF;
          rx_bit_cnt <= '0;
        end
        RX_WAIT_HIGH: rx_baud <= BAUD_HALF;
        default: begin
          if (rx_baud == '0) begin
            rx_baud <= BAUD_LAST;
            if (rx_state == RX_DATA) begin
              rx_shift   <= {rx_s2, rx_shift[7:1]};
              rx_bit_cnt <= rx_bit_cnt + 3'd1;
            end
          end else begin
            rx_baud <= rx_baud - BW'(1);
          end
        end
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] rx_count;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  assign rx_full              = (rx_count == FULL_CNT);
  assign rx_empty             = (rx_count == '0);
  assign rx_pop               = bus.serial_rden_in & ~rx_empty;
  assign rx_push              = rx_push_req & (~rx_full | rx_pop);
  assign bus.serial_valid_out = ~rx_empty;
  assign bus.serial_data_out  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  // RX FIFO pointers and occupancy; push and pop at full leave the count alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clock) begin
    if (reset && rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      if (rx_push_req && !rx_push) rx_overrun_out   <= 1'b1;
      if (rx_ferr_set)             rx_frame_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_my_serial_port.sv
// Bench for my_serial_port: a queue-based model of both directions is checked
// against the DUT on every cycle, plus literal expectations from hand-worked frames.
module tb_my_serial_port;
  localparam int CPB    = 8;
  localparam int DEPTH  = 4;
  // Edge at which a received byte lands, counted from the first edge that sees the start bit.
  localparam int RX_LAT = 2 + CPB / 2 + 9 * CPB;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic uart_rxd_in = 1'b1;
  logic uart_txd_out, rx_overrun_out, rx_frame_err_out;

  my_serial_port_if bus();

  my_serial_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .uart_rxd_in      (uart_rxd_in),
    .uart_txd_out     (uart_txd_out),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  bit model_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [7:0] data;
    bit         ok;
  } rx_ev_t;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  rx_ev_t     rx_pend[$];
  bit         tx_active = 1'b0;
  int         tx_p = 0;
  logic [7:0] tx_cur = 8'h00;
  logic       exp_txd = 1'b1;
  bit         exp_ovr = 1'b0;
  bit         exp_ferr = 1'b0;

  // Line level of bit slot idx of an 8N1 frame: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  always @(posedge clock) begin : model
    int     k;
    bit     tp, tw, rp, full_b;
    rx_ev_t ev;
    k = edge_n;
    if (!reset) begin
      txq.delete();
      rxq.delete();
      rx_pend.delete();
      tx_active = 1'b0;
      exp_txd   = 1'b1;
      exp_ovr   = 1'b0;
      exp_ferr  = 1'b0;
      model_on  = 1'b1;
    end else begin
      // A frame popped at edge P occupies edges P+1..P+10*CPB; next pop no earlier than P+10*CPB+1.
      tp = (txq.size() > 0) && (!tx_active || k >= tx_p + 10 * CPB + 1);
      tw = bus.serial_wren_in && (txq.size() < DEPTH);
      if (tp) begin
        tx_cur    = txq.pop_front();
        tx_p      = k;
        tx_active = 1'b1;
      end
      if (tw) txq.push_back(bus.serial_data_in);
      if (tx_active && k >= tx_p + 1 && k <= tx_p + 10 * CPB)
        exp_txd = frame_bit(tx_cur, (k - tx_p - 1) / CPB);
      else
        exp_txd = 1'b1;

      full_b = (rxq.size() == DEPTH);
      rp     = bus.serial_rden_in && (rxq.size() > 0);
      if (rp) void'(rxq.pop_front());
      if (rx_pend.size() > 0 && rx_pend[0].due == k) begin
        ev = rx_pend.pop_front();
        if (!ev.ok)              exp_ferr = 1'b1;
        else if (full_b && !rp)  exp_ovr  = 1'b1;
        else                     rxq.push_back(ev.data);
      end
    end
    edge_n++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (model_on) begin
      check("txd",       {31'd0, uart_txd_out},         {31'd0, exp_txd});
      check("ready",     {31'd0, bus.serial_ready_out}, {31'd0, txq.size() != DEPTH});
      check("valid",     {31'd0, bus.serial_valid_out}, {31'd0, rxq.size() != 0});
      check("data_out",  {24'd0, bus.serial_data_out},  {24'd0, (rxq.size() != 0) ? rxq[0] : 8'h00});
      check("overrun",   {31'd0, rx_overrun_out},       {31'd0, exp_ovr});
      check("frame_err", {31'd0, rx_frame_err_out},     {31'd0, exp_ferr});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clock);
    bus.serial_data_in = d;
    bus.serial_wren_in = 1'b1;
    @(negedge clock);
    bus.serial_wren_in = 1'b0;
  endtask

  // Drive one 8N1 frame; abort_at >= 0 returns the line high at that cycle.
  task automatic rx_frame(input logic [7:0] d, input bit stop_ok, input int abort_at);
    logic [9:0] bits;
    rx_ev_t     ev;
    bit         stop;
    bits = {stop_ok, d, 1'b0};
    stop = 1'b0;
    for (int k = 0; k < 10 * CPB && !stop; k++) begin
      @(negedge clock);
      if (k == abort_at) begin
        uart_rxd_in = 1'b1;
        stop = 1'b1;
      end else begin
        if (k == 0) begin
          ev.due  = edge_n + RX_LAT;
          ev.data = d;
          ev.ok   = stop_ok;
          rx_pend.push_back(ev);
        end
        uart_rxd_in = bits[k / CPB];
      end
    end
    if (!stop) begin
      @(negedge clock);
      uart_rxd_in = 1'b1;
    end
  endtask

  task automatic rx_pop_expect(input string name, input logic [7:0] exp);
    @(negedge clock);
    check(name, {24'd0, bus.serial_data_out}, {24'd0, exp});
    bus.serial_rden_in = 1'b1;
    @(negedge clock);
    bus.serial_rden_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] s1_bits;
    bus.serial_data_in = 8'h00;
    bus.serial_wren_in = 1'b0;
    bus.serial_rden_in = 1'b0;

    do_reset();
    check("rst_txd",   {31'd0, uart_txd_out},         32'd1);
    check("rst_ready", {31'd0, bus.serial_ready_out}, 32'd1);
    check("rst_valid", {31'd0, bus.serial_valid_out}, 32'd0);
    check("rst_data",  {24'd0, bus.serial_data_out},  32'd0);
    check("rst_ovr",   {31'd0, rx_overrun_out},       32'd0);
    check("rst_ferr",  {31'd0, rx_frame_err_out},     32'd0);

    // 1: transmit 0xA5, start bit two edges after the accepting edge.
    tx_write(8'hA5);
    @(negedge clock);
    check("s1_pre_start", {31'd0, uart_txd_out}, 32'd1);
    @(negedge clock);
    check("s1_start", {31'd0, uart_txd_out}, 32'd0);
    s1_bits = 9'b1_1010_0101;
    repeat (4) @(negedge clock);
    for (int j = 1; j <= 9; j++) begin
      repeat (8) @(negedge clock);
      check($sformatf("s1_bit%0d", j), {31'd0, uart_txd_out}, {31'd0, s1_bits[j-1]});
    end
    repeat (3) @(negedge clock);
    check("s1_last_stop", {31'd0, uart_txd_out}, 32'd1);
    @(negedge clock);
    check("s1_idle", {31'd0, uart_txd_out}, 32'd1);
    repeat (5) @(negedge clock);

    // 2: six writes with wren held; the first is popped immediately, so byte 6 is dropped.
    @(negedge clock);
    bus.serial_wren_in = 1'b1;
    for (int d = 1; d <= 6; d++) begin
      bus.serial_data_in = 8'(d);
      @(negedge clock);
    end
    bus.serial_wren_in = 1'b0;
    check("s2_full", {31'd0, bus.serial_ready_out}, 32'd0);
    repeat (76) @(negedge clock);
    check("s2_still_full", {31'd0, bus.serial_ready_out}, 32'd0);
    @(negedge clock);
    check("s2_ready_rise", {31'd0, bus.serial_ready_out}, 32'd1);
    repeat (420) @(negedge clock);

    // 3: receive 0x3C and pop it.
    rx_frame(8'h3C, 1'b1, -1);
    check("s3_valid", {31'd0, bus.serial_valid_out}, 32'd1);
    rx_pop_expect("s3_data", 8'h3C);
    check("s3_empty_valid", {31'd0, bus.serial_valid_out}, 32'd0);
    check("s3_empty_data",  {24'd0, bus.serial_data_out},  32'd0);

    // 4: overrun, then a pop coinciding with a push at full.
    for (int i = 0; i < 5; i++) rx_frame(8'(8'h10 + i), 1'b1, -1);
    check("s4_overrun", {31'd0, rx_overrun_out},      32'd1);
    check("s4_head",    {24'd0, bus.serial_data_out}, 32'h10);
    fork
      rx_frame(8'h15, 1'b1, -1);
      begin
        @(negedge clock);
        repeat (RX_LAT) @(negedge clock);
        bus.serial_rden_in = 1'b1;
        @(negedge clock);
        bus.serial_rden_in = 1'b0;
      end
    join
    rx_pop_expect("s4_pop1", 8'h11);
    rx_pop_expect("s4_pop2", 8'h12);
    rx_pop_expect("s4_pop3", 8'h13);
    rx_pop_expect("s4_pop4", 8'h15);
    check("s4_drained", {31'd0, bus.serial_valid_out}, 32'd0);

    // 5: bad stop bit, then a short glitch, then a good frame.
    rx_frame(8'h55, 1'b0, -1);
    check("s5_ferr",  {31'd0, rx_frame_err_out},     32'd1);
    check("s5_valid", {31'd0, bus.serial_valid_out}, 32'd0);
    repeat (5) @(negedge clock);
    uart_rxd_in = 1'b0;
    repeat (3) @(negedge clock);
    uart_rxd_in = 1'b1;
    repeat (30) @(negedge clock);
    check("s5_glitch_valid", {31'd0, bus.serial_valid_out}, 32'd0);
    rx_frame(8'hA3, 1'b1, -1);
    rx_pop_expect("s5_after", 8'hA3);

    // 6: reset in the middle of TX and RX frames.
    rx_frame(8'h77, 1'b1, -1);
    fork
      begin
        @(negedge clock);
        bus.serial_wren_in = 1'b1;
        for (int d = 0; d < 6; d++) begin
          bus.serial_data_in = 8'(8'h81 + d);
          @(negedge clock);
        end
        bus.serial_wren_in = 1'b0;
      end
      rx_frame(8'h5A, 1'b1, 40);
      begin
        repeat (40) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
      end
    join
    check("s6_txd",   {31'd0, uart_txd_out},         32'd1);
    check("s6_valid", {31'd0, bus.serial_valid_out}, 32'd0);
    check("s6_ready", {31'd0, bus.serial_ready_out}, 32'd1);
    check("s6_ovr",   {31'd0, rx_overrun_out},       32'd0);
    check("s6_ferr",  {31'd0, rx_frame_err_out},     32'd0);
    repeat (5) @(negedge clock);
    fork
      tx_write(8'h96);
      rx_frame(8'h69, 1'b1, -1);
    join
    repeat (10) @(negedge clock);
    rx_pop_expect("s6_rx_after", 8'h69);

    // Randomized traffic in both directions.
    fork
      for (int c = 0; c < 2000; c++) begin
        @(negedge clock);
        bus.serial_wren_in = ($urandom_range(0, 7) == 0);
        bus.serial_data_in = 8'($urandom);
      end
      for (int c = 0; c < 2000; c++) begin
        @(negedge clock);
        bus.serial_rden_in = ($urandom_range(0, 3) == 0);
      end
      for (int f = 0; f < 20; f++) begin
        rx_frame(8'($urandom), $urandom_range(0, 5) != 0, -1);
        repeat ($urandom_range(4, 30)) @(negedge clock);
      end
    join
    bus.serial_wren_in = 1'b0;
    bus.serial_rden_in = 1'b0;
    repeat (900) @(negedge clock);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      bus.serial_rden_in = 1'b1;
    end
    @(negedge clock);
    bus.serial_rden_in = 1'b0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
